lc3b_mem_responder: RTL and testbench
=====================================

Name: lc3b_mem_responder

Overview:
- Memory-side responder for the LC-3b multicycle core.
- Serves one read or write at a time, issued by the controller/datapath. Accesses are byte-addressable, word or byte sized, with a configurable wait-state count.
- Uses a req/ready handshake so the controller can stall in its memory states until data is returned or committed.
- Replaces the zero-latency combinational memory model, so multicycle timing and LDB/STB byte paths are exercised.

Parameters:
- DEPTH, 1024, storage size in bytes; power of 2, at least 2.
- LATENCY, 2, wait cycles inserted before ready; range 0..15.
- AW, 16, address width presented by the core.

Ports:
- clk, input, 1, system clock; all state changes on its rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- req, input, 1, access request; sampled only in IDLE.
- we, input, 1, 1 = write, 0 = read; latched with req.
- byte_acc, input, 1, 1 = byte access (LDB/STB), 0 = word access; latched with req.
- addr, input, AW, byte address; latched with req.
- wdata, input, 16, write data; latched with req. Byte writes use wdata[7:0].
- rdata, output, 16, read result; valid while ready=1, held until the next read completes.
- ready, output, 1, single-cycle completion pulse for both reads and writes.
- busy, output, 1, high in WAIT and DONE; the core must not change a request while busy.
- err, output, 1, alignment error flag; only active with the optional feature.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE, ready=0, busy=0, err=0, rdata=16'h0000, wait counter=0.
  - Storage contents are NOT reset.
  - Reset mid-access aborts it: no write is committed and no ready pulse is produced.
- FSM states: IDLE, WAIT, DONE.
  - IDLE: on a rising edge with req=1, latch we/byte_acc/addr/wdata and load cnt=LATENCY. Next state is WAIT if LATENCY>0, else DONE. With req=0, stay in IDLE.
  - WAIT: cnt decrements each cycle; when cnt==1, go to DONE. req is ignored.
  - DONE: ready=1 for exactly one cycle, then unconditionally return to IDLE.
- Timing:
  - If req is sampled at edge E0, ready is high between edge E0+LATENCY and edge E0+LATENCY+1.
  - LATENCY=0 gives ready in the cycle immediately after the accepting edge.
  - A new req can be accepted at the edge ending DONE+1, i.e. the first IDLE cycle. Minimum request spacing is LATENCY+2 cycles.
  - req held high continuously therefore produces back-to-back accesses, one every LATENCY+2 cycles.
- Address mapping:
  - Byte index = addr mod DEPTH; addresses above DEPTH-1 wrap silently.
  - Word access uses a = {addr[AW-1:1],1'b0} mod DEPTH.
  - Words are little-endian: low byte at a, high byte at a+1.
- Reads:
  - rdata is registered on the edge entering DONE.
  - Word read returns {mem[a+1], mem[a]}.
  - Byte read returns mem[addr] sign-extended to 16 bits (LDB semantics).
  - rdata keeps its value through writes and idle cycles.
- Writes:
  - Committed on the edge leaving DONE.
  - Word write: mem[a]=wdata[7:0], mem[a+1]=wdata[15:8].
  - Byte write: mem[addr]=wdata[7:0]; the other byte of that word is untouched.
  - A read issued after a write to the same address returns the new data.
- Inputs changing while busy have no effect; only the latched copies are used.
- Without the optional feature, err is tied to 0 and addr[0] is ignored on word accesses.

Optional Feature:
- Macro: LC3B_MEM_ALIGN_CHECK_EN.
- Defined: a word access with addr[0]=1 still completes with normal handshake timing, but:
  - err=1 during the DONE cycle;
  - a write commits nothing;
  - a read returns rdata=16'h0000.
  - err clears to 0 with ready.
- Undefined: no check is performed, err is a constant 0, and odd word addresses are force-aligned down.

Test Plan:
- Reset then idle: rst_n low for 3 cycles, then high -> ready=0, busy=0, rdata=0000; ready stays 0 for 20 cycles with req=0.
- Word write/read, LATENCY=2: write addr=0x0010 wdata=0xBEEF, then read 0x0010 -> ready exactly 2 cycles after each accepting edge, rdata=BEEF; a byte read at 0x0011 returns FFBE.
- Byte write merge: word write 0x0020=0x1234, byte write 0x0021 with wdata=0x00AB, word read 0x0020 -> rdata=0xAB34; byte read 0x0020 -> 0x0034.
- Wrap and LATENCY=0 build: word write 0x0400 (DEPTH=1024) = 0x5A5A, read 0x0000 -> 5A5A; ready in the cycle right after each accept; req held high -> accesses every 2 cycles.
- Reset mid-write: accept a write of 0xFFFF at 0x0030, assert rst_n=0 during WAIT -> no ready pulse; a subsequent read of 0x0030 returns the prior value.
- Alignment, with LC3B_MEM_ALIGN_CHECK_EN: word write to 0x0041 -> err=1 and ready=1 in the same cycle; memory unchanged; a read of 0x0041 gives rdata=0000 and err=1. Without the macro, the same write stores to 0x0040 and err stays 0.

Source files
------------

// File: rtl/lc3b_mem_responder.sv
// lc3b_mem_responder
//
// Memory-side responder for the LC-3b multicycle core. It serves one read or
// write at a time. Accesses are byte-addressed and either word or byte sized.
// The number of wait states is set by a parameter. A req/ready handshake lets
// the controller stall in its memory states until data is returned or
// committed.
//
// Storage is two byte lanes. Each lane is an inferred RAM with a registered
// read port:
//   - lane 0 holds even byte addresses;
//   - lane 1 holds odd byte addresses.
// A word access therefore touches the same row index in both lanes.
//
// Optional build macro:
//   LC3B_MEM_ALIGN_CHECK_EN - a word access with addr[0]=1 raises err during
//                             DONE. A misaligned write commits nothing and a
//                             misaligned read returns 0. Without the macro,
//                             err is 0 and odd word addresses are aligned down.
//
// Parameters:
//   DEPTH   - storage size in bytes (power of 2, >= 2)
//   LATENCY - wait cycles before ready (0..15)
//   AW      - address width presented by the core
//
// Ports:
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset (storage is not cleared)
//   req      in   access request, sampled only in IDLE
//   we       in   1 = write, 0 = read (latched with req)
//   byte_acc in   1 = byte access (LDB/STB), 0 = word (latched with req)
//   addr     in   byte address, AW bits (latched with req)
//   wdata    in   write data; byte writes use wdata[7:0] (latched with req)
//   rdata    out  read result, held until the next read completes
//   ready    out  one-cycle completion pulse (DONE state)
//   busy     out  high in WAIT and DONE
//   err      out  misaligned word access flag (optional feature only)

module lc3b_mem_responder #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2,
    parameter int AW      = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req,
    input  logic          we,
    input  logic          byte_acc,
    input  logic [AW-1:0] addr,
    input  logic [15:0]   wdata,
    output logic [15:0]   rdata,
    output logic          ready,
    output logic          busy,
    output logic          err
);

    // Row index width inside one byte lane. It is kept at least 1 bit wide
    // so that the degenerate DEPTH=2 case still elaborates.
    localparam int LANE_DEPTH = DEPTH / 2;
    localparam int IW         = (DEPTH > 2) ? $clog2(LANE_DEPTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t        state_reg, state_next;
    logic [3:0]    cnt_reg, cnt_next;
    logic          enter_done;

    // Request fields captured at the accepting edge.
    logic          we_reg;
    logic          byte_reg;
    logic [AW-1:0] addr_reg;
    logic [15:0]   wdata_reg;
    logic          misalign_reg;

    // Misalignment of the request currently on the inputs.
    logic          misalign_in;

    // Fields of the access being completed. In IDLE they come from the
    // inputs; this matters only when LATENCY=0, where the accepting edge is
    // also the edge entering DONE. In the other states they come from the
    // latched copies.
    logic          acc_we;
    logic          acc_byte;
    logic [AW-1:0] acc_addr;
    logic          acc_misalign;

    logic          accept;
    logic          rd_load;
    logic          commit;

    logic [IW-1:0] rd_idx;
    logic [IW-1:0] wr_idx;
    logic [1:0]    lane_wen;
    logic [15:0]   lane_wdata;
    logic [15:0]   lane_q;

    // Formatting of the registered lane data into rdata. It is captured
    // together with the lane read so that rdata holds across later writes.
    logic          rd_zero_reg;
    logic          rd_byte_reg;
    logic          rd_hi_reg;
    logic [7:0]    rd_sel_byte;

    // High address bits beyond the storage size wrap silently and are not
    // used anywhere.
    logic          unused_addr_bits;
    assign unused_addr_bits = ^{addr, addr_reg};

`ifdef LC3B_MEM_ALIGN_CHECK_EN
    assign misalign_in = ~byte_acc & addr[0];
`else
    assign misalign_in = 1'b0;
`endif

    assign accept = (state_reg == S_IDLE) && req;

    always_comb begin
        acc_we       = we_reg;
        acc_byte     = byte_reg;
        acc_addr     = addr_reg;
        acc_misalign = misalign_reg;
        if (state_reg == S_IDLE) begin
            acc_we       = we;
            acc_byte     = byte_acc;
            acc_addr     = addr;
            acc_misalign = misalign_in;
        end
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
            cnt_reg   <= 4'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        enter_done = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (req) begin
                    cnt_next = 4'(LATENCY);
                    if (LATENCY == 0) begin
                        state_next = S_DONE;
                        enter_done = 1'b1;
                    end else begin
                        state_next = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                cnt_next = cnt_reg - 4'd1;
                if (cnt_reg == 4'd1) begin
                    state_next = S_DONE;
                    enter_done = 1'b1;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign ready = (state_reg == S_DONE);
    assign busy  = (state_reg != S_IDLE);

`ifdef LC3B_MEM_ALIGN_CHECK_EN
    assign err = (state_reg == S_DONE) && misalign_reg;
`else
    assign err = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Request capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_reg       <= 1'b0;
            byte_reg     <= 1'b0;
            addr_reg     <= '0;
            wdata_reg    <= 16'h0000;
            misalign_reg <= 1'b0;
        end else if (accept) begin
            we_reg       <= we;
            byte_reg     <= byte_acc;
            addr_reg     <= addr;
            wdata_reg    <= wdata;
            misalign_reg <= misalign_in;
        end
    end

    // ------------------------------------------------------------------
    // Byte-lane storage
    // ------------------------------------------------------------------
    // The read happens on the edge entering DONE. The write happens on the
    // edge leaving DONE. The FSM is reset asynchronously, so a reset during
    // WAIT or DONE means that edge never comes and nothing is committed.
    assign rd_load = enter_done && !acc_we;
    assign commit  = (state_reg == S_DONE) && we_reg && !misalign_reg;

    generate
        if (DEPTH > 2) begin : g_idx
            assign rd_idx = acc_addr[IW:1];
            assign wr_idx = addr_reg[IW:1];
        end else begin : g_idx_one
            assign rd_idx = '0;
            assign wr_idx = '0;
        end
    endgenerate

    // A word access writes both lanes. A byte access writes only the lane
    // selected by addr[0], and that lane takes wdata[7:0].
    assign lane_wen[0]       = commit && (!byte_reg || !addr_reg[0]);
    assign lane_wen[1]       = commit && (!byte_reg ||  addr_reg[0]);
    assign lane_wdata[7:0]   = wdata_reg[7:0];
    assign lane_wdata[15:8]  = byte_reg ? wdata_reg[7:0] : wdata_reg[15:8];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lane
            logic [7:0] mem [LANE_DEPTH];
            logic [7:0] q_reg;

            always_ff @(posedge clk) begin
                if (lane_wen[gi]) begin
                    mem[wr_idx] <= lane_wdata[gi*8 +: 8];
                end
                if (rd_load) begin
                    q_reg <= mem[rd_idx];
                end
            end

            assign lane_q[gi*8 +: 8] = q_reg;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Read formatting
    // ------------------------------------------------------------------
    // rd_zero_reg resets to 1, so rdata reads 0 after reset even though the
    // lane read registers hold no defined value yet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_zero_reg <= 1'b1;
            rd_byte_reg <= 1'b0;
            rd_hi_reg   <= 1'b0;
        end else if (rd_load) begin
            rd_zero_reg <= acc_misalign;
            rd_byte_reg <= acc_byte;
            rd_hi_reg   <= acc_addr[0];
        end
    end

    assign rd_sel_byte = rd_hi_reg ? lane_q[15:8] : lane_q[7:0];

    always_comb begin
        rdata = lane_q;
        if (rd_zero_reg) begin
            rdata = 16'h0000;
        end else if (rd_byte_reg) begin
            // LDB: sign-extend the selected byte.
            rdata = {{8{rd_sel_byte[7]}}, rd_sel_byte};
        end
    end

endmodule

// File: tb/tb_lc3b_mem_responder.sv
// Directed bench for lc3b_mem_responder. It uses two instances:
//   dut  - default build, LATENCY=2;
//   dut0 - LATENCY=0, for the wrap and back-to-back cases.
// Both instances share the request fields. Each instance has its own req.
module tb_lc3b_mem_responder;

    logic        clk;
    logic        rst_n;
    logic        req, req0;
    logic        we, byte_acc;
    logic [15:0] addr, wdata;
    logic [15:0] rdata, rdata0;
    logic        ready, ready0, busy, busy0, err, err0;

    int          n_assert;
    int          n_fail;

    lc3b_mem_responder #(.DEPTH(1024), .LATENCY(2), .AW(16)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .byte_acc(byte_acc),
        .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready),
        .busy(busy), .err(err)
    );

    lc3b_mem_responder #(.DEPTH(1024), .LATENCY(0), .AW(16)) dut0 (
        .clk(clk), .rst_n(rst_n), .req(req0), .we(we), .byte_acc(byte_acc),
        .addr(addr), .wdata(wdata), .rdata(rdata0), .ready(ready0),
        .busy(busy0), .err(err0)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One access on the LATENCY=2 instance. The handshake timing is checked
    // on every cycle, and the request inputs are scrambled while busy.
    task automatic access2(input string tag, input logic w, input logic b,
                           input logic [15:0] a, input logic [15:0] d,
                           output logic [15:0] rd, output logic e);
        @(negedge clk);
        req = 1'b1; we = w; byte_acc = b; addr = a; wdata = d;
        @(posedge clk); #1;
        req = 1'b0; we = ~w; byte_acc = ~b; addr = ~a; wdata = 16'hDEAD;
        check({tag, "_e1_ready"}, 16'(ready), 16'd0);
        check({tag, "_e1_busy"},  16'(busy),  16'd1);
        @(posedge clk); #1;
        check({tag, "_e2_ready"}, 16'(ready), 16'd0);
        @(posedge clk); #1;
        check({tag, "_e3_ready"}, 16'(ready), 16'd1);
        rd = rdata;
        e  = err;
        @(posedge clk); #1;
        check({tag, "_e4_ready"}, 16'(ready), 16'd0);
        check({tag, "_e4_busy"},  16'(busy),  16'd0);
        check({tag, "_e4_err"},   16'(err),   16'd0);
    endtask

    // One access on the LATENCY=0 instance. ready is expected in the cycle
    // right after the accepting edge.
    task automatic access0(input string tag, input logic w, input logic b,
                           input logic [15:0] a, input logic [15:0] d,
                           output logic [15:0] rd);
        @(negedge clk);
        req0 = 1'b1; we = w; byte_acc = b; addr = a; wdata = d;
        @(posedge clk); #1;
        req0 = 1'b0; we = ~w; addr = ~a; wdata = 16'hDEAD;
        check({tag, "_e1_ready"}, 16'(ready0), 16'd1);
        check({tag, "_e1_busy"},  16'(busy0),  16'd1);
        rd = rdata0;
        @(posedge clk); #1;
        check({tag, "_e2_ready"}, 16'(ready0), 16'd0);
        check({tag, "_e2_busy"},  16'(busy0),  16'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] rd;
        logic        e;
        int          cnt;

        n_assert = 0;
        n_fail   = 0;
        clk = 1'b0; rst_n = 1'b0; req = 1'b0; req0 = 1'b0;
        we = 1'b0; byte_acc = 1'b0; addr = 16'h0000; wdata = 16'h0000;

        // Reset, then idle.
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready",  16'(ready),  16'd0);
        check("rst_busy",   16'(busy),   16'd0);
        check("rst_err",    16'(err),    16'd0);
        check("rst_rdata",  rdata,       16'h0000);
        check("rst_rdata0", rdata0,      16'h0000);
        check("rst_ready0", 16'(ready0), 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (ready || ready0 || busy || busy0) cnt++;
        end
        check("idle_quiet", 16'(cnt), 16'd0);
        check("idle_rdata", rdata, 16'h0000);

        // Word write and read, then a byte read of the high byte.
        access2("wr10", 1'b1, 1'b0, 16'h0010, 16'hBEEF, rd, e);
        check("wr10_rdata_held", rd, 16'h0000);
        access2("rd10", 1'b0, 1'b0, 16'h0010, 16'h0000, rd, e);
        check("rd10_rdata", rd, 16'hBEEF);
        access2("rdb11", 1'b0, 1'b1, 16'h0011, 16'h0000, rd, e);
        check("rdb11_rdata", rd, 16'hFFBE);
        check("rdb11_held", rdata, 16'hFFBE);

        // Byte write merged into an existing word.
        access2("wr20", 1'b1, 1'b0, 16'h0020, 16'h1234, rd, e);
        access2("wrb21", 1'b1, 1'b1, 16'h0021, 16'h00AB, rd, e);
        check("wrb21_rdata_held", rd, 16'hFFBE);
        access2("rd20", 1'b0, 1'b0, 16'h0020, 16'h0000, rd, e);
        check("rd20_rdata", rd, 16'hAB34);
        access2("rdb20", 1'b0, 1'b1, 16'h0020, 16'h0000, rd, e);
        check("rdb20_rdata", rd, 16'h0034);

        // LATENCY=0: the address wraps, and a held req gives back-to-back
        // accesses.
        access0("wr400", 1'b1, 1'b0, 16'h0400, 16'h5A5A, rd);
        access0("rd000", 1'b0, 1'b0, 16'h0000, 16'h0000, rd);
        check("rd000_rdata", rd, 16'h5A5A);
        access0("rd401", 1'b0, 1'b0, 16'h0401, 16'h0000, rd);
        check("rd401_aligned", rd, 16'h5A5A);
        @(negedge clk);
        req0 = 1'b1; we = 1'b0; byte_acc = 1'b1; addr = 16'h0401; wdata = 16'h0000;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check($sformatf("b2b_ready_%0d", i), 16'(ready0), (i % 2 == 0) ? 16'd1 : 16'd0);
        end
        req0 = 1'b0;
        check("b2b_rdata", rdata0, 16'h005A);
        @(posedge clk); #1;
        check("b2b_end_ready", 16'(ready0), 16'd0);
        @(posedge clk); #1;
        check("b2b_end_busy", 16'(busy0), 16'd0);

        // Reset during WAIT aborts the write.
        access2("wr30", 1'b1, 1'b0, 16'h0030, 16'h1357, rd, e);
        @(negedge clk);
        req = 1'b1; we = 1'b1; byte_acc = 1'b0; addr = 16'h0030; wdata = 16'hFFFF;
        @(posedge clk); #1;
        req = 1'b0;
        check("abort_busy_before", 16'(busy), 16'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy",  16'(busy),  16'd0);
        check("abort_ready", 16'(ready), 16'd0);
        check("abort_rdata", rdata,      16'h0000);
        cnt = 0;
        repeat (2) begin
            @(posedge clk); #1;
            if (ready) cnt++;
        end
        check("abort_no_ready", 16'(cnt), 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        access2("rd30", 1'b0, 1'b0, 16'h0030, 16'h0000, rd, e);
        check("rd30_rdata", rd, 16'h1357);

        // Word accesses at an odd address.
        access2("wr40", 1'b1, 1'b0, 16'h0040, 16'h1111, rd, e);
        access2("wr41", 1'b1, 1'b0, 16'h0041, 16'hC0DE, rd, e);
`ifdef LC3B_MEM_ALIGN_CHECK_EN
        check("wr41_err", 16'(e), 16'd1);
`else
        check("wr41_err", 16'(e), 16'd0);
`endif
        access2("rd40", 1'b0, 1'b0, 16'h0040, 16'h0000, rd, e);
`ifdef LC3B_MEM_ALIGN_CHECK_EN
        check("rd40_rdata", rd, 16'h1111);
`else
        check("rd40_rdata", rd, 16'hC0DE);
`endif
        check("rd40_err", 16'(e), 16'd0);
        access2("rd41", 1'b0, 1'b0, 16'h0041, 16'h0000, rd, e);
`ifdef LC3B_MEM_ALIGN_CHECK_EN
        check("rd41_rdata", rd, 16'h0000);
        check("rd41_err", 16'(e), 16'd1);
`else
        check("rd41_rdata", rd, 16'hC0DE);
        check("rd41_err", 16'(e), 16'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
